sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 Parameter DEV_ID, default 8'h42, write device ID; read ID is DEV_ID|1 (8'h43).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in.
REQ-003 clk  input  1  system clock, at least 20x SCL rate (100 MHz nominal vs 100 kHz SCL).
REQ-004 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-005 scl_in  input  1  raw SCCB clock from bus (asynchronous to clk).
REQ-006 sda_in  input  1  raw SCCB data from bus (asynchronous to clk).
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 wr_valid  output  1  one-cycle pulse per accepted register write.
REQ-009 wr_addr  output  8  sub-address of the accepted write; valid with wr_valid.
REQ-010 wr_data  output  8  data of the accepted write; valid with wr_valid.
REQ-011 soft_rst  output  1  one-cycle pulse when 0x80 bit is written to sub-address 0x12.
REQ-012 busy  output  1  high from START detect until STOP detect.

Function
REQ-013 scl_in/sda_in SHALL pass through SYNC_STAGES flops; all edge detection uses synchronized values plus one history flop.
REQ-014 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both evaluated every clk, in any state.
REQ-015 START (incl. repeated START) in any state SHALL enter ID, clear bit counter, release sda_oe next cycle.
REQ-016 STOP in any state SHALL enter IDLE, release sda_oe, deassert busy next cycle; an incomplete data byte is discarded.
REQ-017 Bits SHALL be sampled on synchronized SCL rising edge, MSB first; sda_oe changes only on the clk after a synchronized SCL falling edge.
REQ-018 States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
REQ-019 ID: after 8 bits, byte==DEV_ID -> ID_ACK (write); byte==DEV_ID|1 -> ID_ACK (read); otherwise IGNORE (no ACK) until START/STOP.
REQ-020 *_ACK states: drive sda_oe=1 from the 8th SCL falling edge to the 9th SCL falling edge; then write ID -> SUB, SUB_ACK -> WDATA, WDATA_ACK -> WDATA, read ID -> RDATA.
REQ-021 SUB: 8 received bits load the internal sub-address pointer (8 bits).
REQ-022 WDATA: on the 8th sampled bit, store byte into internal 256x8 register file at pointer, pulse wr_valid with wr_addr/wr_data, then increment pointer modulo 256 (0xFF wraps to 0x00).
REQ-023 RDATA: load register file[pointer] at the ID_ACK exit; sda_oe = ~bit, MSB first, each bit set up after SCL falling edge; after 8 bits release SDA and enter RD_ACK.
REQ-024 RD_ACK: sample master bit on SCL rise; 0 (ACK) -> increment pointer, reload, RDATA; 1 (NACK) -> increment pointer, IGNORE.
REQ-025 soft_rst SHALL pulse in the same cycle as wr_valid when wr_addr==8'h12 and wr_data[7]==1; the register file SHALL then hold 0x00 at every address except 0x12, which keeps the written byte, visible to the next read.
REQ-026 START and STOP detected in the same cycle cannot occur (needs two SDA edges); SDA edges while SCL low SHALL never be treated as START/STOP.
REQ-027 wr_valid and soft_rst SHALL never assert outside WDATA.

Reset
REQ-028 rst asserted: state=IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, soft_rst=0, busy=0, pointer=0, register file all 0x00, sync flops=1 (bus idle).
REQ-029 rst mid-transfer SHALL abort immediately; after release the block waits for a fresh START and ignores remaining bits.

Verification
REQ-030 Write 42/12/04 then STOP -> three ACK low pulses, wr_valid once with wr_addr=0x12, wr_data=0x04, busy low after STOP.
REQ-031 Write 42/8C/03, then 42/8C + repeated START + 43, master NACK -> responder drives 0x03, pointer ends 0x8D.
REQ-032 Write 42/FF/AA/BB -> wr_valid at addr 0xFF (0xAA) then 0x00 (0xBB); wrap verified.
REQ-033 ID 0x60 -> sda_oe stays 0 for the whole frame, no wr_valid.
REQ-034 Write 42/15/20, then 42/12/80 -> soft_rst pulse; read 0x15 returns 0x00, read 0x12 returns 0x80.
REQ-035 rst pulsed after 4 bits of data byte, then STOP -> no wr_valid, all outputs at reset values, next full write accepted normally.

Source files
------------

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB/I2C-style register responder with a 256x8 register file.
// Write: ID, sub-address, data bytes (auto-increment); read: ID|1, data bytes from the pointer.
module sccb_responder #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       soft_rst,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             sh_q, sh_d, ptr_q, ptr_d;
  logic                   rd_q, rd_d;
  logic                   sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d;
  logic                   soft_rst_q, soft_rst_d, busy_q, busy_d;
  logic [7:0]             wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [7:0]             mem_q [256];
  logic [7:0]             mem_d [256];
  logic                   scl, sda, scl_rise, scl_fall, start, stop;
  logic [7:0]             byte_in;

  assign scl      = scl_sync_q[SYNC_STAGES-1];
  assign sda      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_prev_q;
  assign scl_fall = ~scl & scl_prev_q;
  // SCL must be high on both samples so SDA moves during SCL-low never count
  assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;
  assign byte_in  = {sh_q[6:0], sda};

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign soft_rst = soft_rst_q;
  assign busy     = busy_q;

  always_comb begin
    scl_sync_d = SYNC_STAGES'({scl_sync_q, scl_in});
    sda_sync_d = SYNC_STAGES'({sda_sync_q, sda_in});
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    ptr_d      = ptr_q;
    rd_d       = rd_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    soft_rst_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = start | (busy_q & ~stop);
    mem_d      = mem_q;
    if (start) begin
      state_d  = ID;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ID, SUB, WDATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == ID) begin
              rd_d    = byte_in[0];
              state_d = (byte_in == DEV_ID || byte_in == (DEV_ID | 8'h01)) ? ID_ACK : IGNORE;
            end else if (state_q == SUB) begin
              ptr_d   = byte_in;
              state_d = SUB_ACK;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              soft_rst_d = (ptr_q == 8'h12) && byte_in[7];
              // soft reset clears everything except the byte that triggered it
              if (soft_rst_d)
                for (int i = 0; i < 256; i++) mem_d[i] = '0;
              mem_d[ptr_q] = byte_in;
              ptr_d        = ptr_q + 8'd1;
              state_d      = WDATA_ACK;
            end
          end
        end
        ID_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) sda_oe_d = 1'b1;
          else begin
            sda_oe_d = 1'b0;
            state_d  = (state_q != ID_ACK) ? WDATA : (rd_q ? RDATA : SUB);
            if (state_q == ID_ACK && rd_q) begin
              sh_d     = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
              cnt_d    = '0;
            end
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall) begin
            sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~sh_q[3'd7 - cnt_q[2:0]];
            state_d  = (cnt_q == 4'd8) ? RD_ACK : RDATA;
            cnt_d    = (cnt_q == 4'd8) ? 4'd0 : cnt_q;
          end
        end
        RD_ACK: if (scl_rise) begin
          ptr_d   = ptr_q + 8'd1;
          sh_d    = mem_q[ptr_q + 8'd1];
          state_d = sda ? IGNORE : RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      rd_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      soft_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl;
      sda_prev_q <= sda;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      soft_rst_q <= soft_rst_d;
      busy_q     <= busy_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-banged SCCB master against a byte-level register-file model.
module tb_sccb_responder;
  localparam int Q = 6;
  logic clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_m = 1'b1;
  logic sda_in, sda_oe, wr_valid, soft_rst, busy;
  logic [7:0] wr_addr, wr_data;
  int errors = 0, checks = 0, wr_cnt = 0, soft_cnt = 0, oe_cnt = 0;
  logic [7:0] log_addr [1024];
  logic [7:0] log_data [1024];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr = 8'h00;

  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  sccb_responder dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .soft_rst(soft_rst), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      log_addr[wr_cnt & 1023] = wr_addr;
      log_data[wr_cnt & 1023] = wr_data;
      wr_cnt++;
    end
    if (soft_rst) soft_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q); scl_in = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_in = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(Q); scl_in = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; tick(Q); scl_in = 1'b1; tick(Q); s = sda_in; tick(Q); scl_in = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic m_wr(input logic [7:0] d);
    if (ref_ptr == 8'h12 && d[7])
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[ref_ptr] = d;
    ref_ptr++;
  endtask

  task automatic do_write(input logic [7:0] sub, input int n, input logic [31:0] dv);
    logic ack;
    logic [7:0] d;
    int w0, s0;
    start_c();
    chk("busy_start", busy, 1);
    write_byte(8'h42, ack); chk("wr_id_ack", ack, 1);
    write_byte(sub, ack); chk("sub_ack", ack, 1);
    ref_ptr = sub;
    for (int i = 0; i < n; i++) begin
      d = dv[31-8*i -: 8];
      w0 = wr_cnt; s0 = soft_cnt;
      write_byte(d, ack);
      chk("data_ack", ack, 1);
      chk("wr_count", wr_cnt - w0, 1);
      chk("wr_addr", log_addr[w0 & 1023], ref_ptr);
      chk("wr_data", log_data[w0 & 1023], d);
      chk("soft_rst", soft_cnt - s0, 32'(ref_ptr == 8'h12 && d[7]));
      m_wr(d);
    end
    stop_c();
    chk("busy_stop", busy, 0);
  endtask

  task automatic do_read(input logic setp, input logic [7:0] sub, input int n, output logic [7:0] last);
    logic ack;
    logic [7:0] d;
    int w0;
    w0 = wr_cnt;
    start_c();
    if (setp) begin
      write_byte(8'h42, ack); chk("rs_id_ack", ack, 1);
      write_byte(sub, ack); chk("rs_sub_ack", ack, 1);
      ref_ptr = sub;
      start_c();
    end
    write_byte(8'h43, ack); chk("rd_id_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk("rd_data", d, ref_mem[ref_ptr]);
      ref_ptr++;
      last = d;
    end
    stop_c();
    chk("rd_no_write", wr_cnt - w0, 0);
    chk("rd_busy_stop", busy, 0);
  endtask

  typedef struct {
    logic [7:0] id, sub, dat;
    logic       ack;
  } vec_t;

  initial begin
    vec_t vecs [6];
    logic ack, s;
    logic [7:0] last;
    int w0, o0, s0;
    vecs = '{
      '{8'h42, 8'h12, 8'h04, 1'b1}, '{8'h60, 8'h12, 8'h55, 1'b0},
      '{8'h40, 8'h00, 8'hFF, 1'b0}, '{8'h42, 8'h20, 8'hA5, 1'b1},
      '{8'hC2, 8'h20, 8'h11, 1'b0}, '{8'h42, 8'h7F, 8'h00, 1'b1}
    };
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    tick(3); rst = 1'b0; tick(3);
    chk("rst_sda_oe", sda_oe, 0); chk("rst_busy", busy, 0); chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0); chk("rst_soft", soft_rst, 0);

    foreach (vecs[k]) begin
      w0 = wr_cnt; o0 = oe_cnt;
      start_c();
      write_byte(vecs[k].id, ack); chk("vec_id_ack", ack, vecs[k].ack);
      write_byte(vecs[k].sub, ack); chk("vec_sub_ack", ack, vecs[k].ack);
      write_byte(vecs[k].dat, ack); chk("vec_dat_ack", ack, vecs[k].ack);
      stop_c();
      chk("vec_busy", busy, 0);
      chk("vec_wr_count", wr_cnt - w0, 32'(vecs[k].ack));
      if (vecs[k].ack) begin
        chk("vec_wr_addr", log_addr[w0 & 1023], vecs[k].sub);
        chk("vec_wr_data", log_data[w0 & 1023], vecs[k].dat);
        ref_ptr = vecs[k].sub;
        m_wr(vecs[k].dat);
      end else chk("vec_no_oe", oe_cnt - o0, 0);
    end

    do_write(8'h8C, 2, 32'h035A_0000);
    do_read(1'b1, 8'h8C, 1, last);
    chk("rs_read_8c", last, 8'h03);
    do_read(1'b0, 8'h00, 1, last);
    chk("ptr_after_nack", last, 8'h5A);

    w0 = wr_cnt;
    do_write(8'hFF, 2, 32'hAABB_0000);
    chk("wrap_addr0", log_addr[w0 & 1023], 8'hFF);
    chk("wrap_addr1", log_addr[(w0 + 1) & 1023], 8'h00);
    chk("wrap_data1", log_data[(w0 + 1) & 1023], 8'hBB);

    s0 = soft_cnt;
    do_write(8'h15, 1, 32'h2000_0000);
    do_write(8'h12, 1, 32'h8000_0000);
    chk("soft_pulse", soft_cnt - s0, 1);
    do_read(1'b1, 8'h15, 1, last); chk("soft_cleared", last, 8'h00);
    do_read(1'b1, 8'h12, 1, last); chk("soft_kept", last, 8'h80);

    do_write(8'h40, 2, 32'h1122_0000);
    do_read(1'b1, 8'h40, 2, last); chk("burst_read_last", last, 8'h22);

    w0 = wr_cnt;
    start_c();
    write_byte(8'h42, ack);
    write_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    rst = 1'b1; tick(2);
    chk("mid_rst_oe", sda_oe, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", wr_addr, 0); chk("mid_rst_data", wr_data, 0);
    rst = 1'b0; tick(2);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    chk("mid_rst_no_ack", s, 1);
    stop_c();
    chk("mid_rst_no_wr", wr_cnt - w0, 0);
    chk("mid_rst_busy_end", busy, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    do_write(8'h31, 1, 32'h7700_0000);
    do_read(1'b1, 8'h12, 1, last); chk("mid_rst_mem_clear", last, 8'h00);
    do_read(1'b1, 8'h31, 1, last); chk("mid_rst_new_write", last, 8'h77);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), $urandom_range(1, 3), $urandom);
        1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3), last);
        default: do_read(1'b0, 8'h00, $urandom_range(1, 2), last);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
